snitch_icache_l0_refill_arbiter: RTL and testbench
==================================================

Name: snitch_icache_l0_refill_arbiter

Overview:
Shares the single L1 refill request/response channel between NR_PORTS private L0 line caches. Demand refills win over prefetches, and within each class the ports are served round-robin. Each port has a cap on outstanding refills. Responses are routed back to the issuing L0 using the port index carried in the transaction ID. The block sits between the per-core L0 instances and the shared L1 lookup stage.

Parameters:
NR_PORTS, 4, number of L0 requesters (≥2)
FETCH_AW, 32, request address width
LINE_WIDTH, 128, refill line width
MAX_OUTSTANDING, 2, max in-flight refills per port (≥1)
AGE_LIMIT, 16, prefetch wait cycles before promotion (aging feature only)
PORT_IDX_W, $clog2(NR_PORTS), derived
ID_W, PORT_IDX_W+1, derived; ID = {port_idx, is_prefetch}

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
in_req_addr_i  in  NR_PORTS×FETCH_AW  per-port line address
in_req_prefetch_i  in  NR_PORTS  1 = prefetch, 0 = demand
in_req_valid_i  in  NR_PORTS  request valid
in_req_ready_o  out  NR_PORTS  request accepted
in_rsp_data_o  out  LINE_WIDTH  refill data, broadcast to all ports
in_rsp_error_o  out  1  refill error, broadcast
in_rsp_id_o  out  ID_W  response ID, broadcast
in_rsp_valid_o  out  NR_PORTS  one-hot response valid
in_rsp_ready_i  in  NR_PORTS  per-port response ready
out_req_addr_o  out  FETCH_AW  L1 request address
out_req_id_o  out  ID_W  {granted port, is_prefetch}
out_req_valid_o  out  1  L1 request valid
out_req_ready_i  in  1  L1 request ready
out_rsp_data_i  in  LINE_WIDTH  L1 response data
out_rsp_error_i  in  1  L1 response error
out_rsp_id_i  in  ID_W  L1 response ID
out_rsp_valid_i  in  1  L1 response valid
out_rsp_ready_o  out  1  L1 response ready

Behaviour:
- Reset (rst_i high, asynchronous): rr_ptr=0, lock=0, all outstanding counters=0. Outputs: out_req_valid_o=0, in_req_ready_o=0. in_rsp_valid_o follows out_rsp_valid_i routing; an L1 response arriving during reset is still forwarded.
- Eligible port: in_req_valid_i[p] and cnt[p] < MAX_OUTSTANDING.
- Arbitration is combinational, zero-cycle latency:
  - If any eligible port has a demand request, pick the demand class; otherwise pick the prefetch class.
  - Within the class, pick the first eligible port at or after rr_ptr, wrapping modulo NR_PORTS.
- State machine, 2 states:
  - IDLE: grant is computed each cycle. out_req_valid_o = any eligible. If a grant occurs and out_req_ready_i=0, latch grant_q and go to LOCKED.
  - LOCKED: out_req_* driven from grant_q and in_req_* of that port; arbitration frozen. Return to IDLE on out_req_ready_i.
  - Requesters must hold valid/addr stable until ready, as in the L0 handshake.
- in_req_ready_o[p] = (granted==p) & out_req_ready_i. Pass-through, no buffering.
- On a request handshake: rr_ptr <= granted+1 mod NR_PORTS, and cnt[granted]++.
- Response routing: p = out_rsp_id_i[ID_W-1:1]. in_rsp_valid_o = out_rsp_valid_i << p. out_rsp_ready_o = in_rsp_ready_i[p].
  - p ≥ NR_PORTS is illegal; drive valid=0 and ready=1 (drop) and assert.
- On a response handshake, cnt[p]--. A request and response handshake on the same port in the same cycle leaves cnt[p] unchanged.
- cnt width: $clog2(MAX_OUTSTANDING+1). Overflow and underflow are asserted-impossible.
- Assertions:
  - out_req stable while valid & !ready
  - grant onehot0
  - no response to a port with cnt==0

Optional Feature:
SNITCH_ICACHE_L0_ARB_AGING_EN
- Defined: per-port age counter.
  - Increments while port p has a pending eligible prefetch that is not granted; saturates at AGE_LIMIT.
  - Clears on that port's handshake or when its valid drops.
  - At AGE_LIMIT the prefetch is treated as demand class.
- Undefined: no age counters. Prefetches can starve indefinitely under continuous demand traffic.

Decomposition:
- Package snitch_icache_pkg: arb_state_e {IDLE, LOCKED}, and the refill request struct {is_prefetch, addr} shared with the L0.
- Sub-module snitch_icache_rr_pick: masked round-robin pick (eligible vector + pointer → onehot + index + valid). Instantiated twice, once for the demand class and once for the prefetch class.

Test Plan:
- Demand beats prefetch: port0 prefetch and port2 demand both valid, rr_ptr=0 → port2 granted, out_req_id_o=3'b100, rr_ptr becomes 3.
- Round-robin fairness: all 4 ports issue demand continuously, ready=1 → grants 0,1,2,3,0 on consecutive cycles.
- Lock stability: grant port1, out_req_ready_i=0 for 3 cycles while port0 raises demand → addr/id stable; port1 completes, then port0 granted next.
- Outstanding cap: MAX_OUTSTANDING=2, port3 issues 2 requests with no response → third request not eligible (ready=0); one response with id={3,0} → port3 eligible next cycle.
- Response routing: out_rsp_id_i=3'b011 with valid, in_rsp_ready_i[1]=0 → only in_rsp_valid_o[1]=1 and out_rsp_ready_o=0; raising ready completes the handshake and cnt[1]--.
- Aging (macro on, AGE_LIMIT=4): port0 prefetch under continuous port1 demand → port0 granted within 5 cycles; with the macro off, never granted.

Source files
------------

// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: types shared by the L0 caches and the L0 refill arbiter.
package snitch_icache_pkg;

  localparam int unsigned REFILL_AW = 32;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic                 is_prefetch;
    logic [REFILL_AW-1:0] addr;
  } refill_req_t;

endpackage

// File: rtl/snitch_icache_rr_pick.sv
// snitch_icache_rr_pick: picks the first eligible bit at or after ptr, wrapping modulo N.
module snitch_icache_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Walking offsets from the far end leaves the closest eligible candidate in idx.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % int'(N));
      if (elig[cand]) idx = cand;
    end
  end

  assign valid  = |elig;
  assign onehot = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/snitch_icache_l0_refill_arbiter.sv
// snitch_icache_l0_refill_arbiter: shares the L1 refill channel among NR_PORTS L0 caches.
// Define SNITCH_ICACHE_L0_ARB_AGING_EN to promote long-waiting prefetches to demand class.
module snitch_icache_l0_refill_arbiter import snitch_icache_pkg::*; #(
  parameter int unsigned NR_PORTS        = 4,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 2,
`ifdef SNITCH_ICACHE_L0_ARB_AGING_EN
  parameter int unsigned AGE_LIMIT       = 16,
`endif
  parameter int unsigned PORT_IDX_W      = $clog2(NR_PORTS),
  parameter int unsigned ID_W            = PORT_IDX_W + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  in_req_addr_i,
  input  logic [NR_PORTS-1:0]                in_req_prefetch_i,
  input  logic [NR_PORTS-1:0]                in_req_valid_i,
  output logic [NR_PORTS-1:0]                in_req_ready_o,
  output logic [LINE_WIDTH-1:0]              in_rsp_data_o,
  output logic                               in_rsp_error_o,
  output logic [ID_W-1:0]                    in_rsp_id_o,
  output logic [NR_PORTS-1:0]                in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]                in_rsp_ready_i,
  output logic [FETCH_AW-1:0]                out_req_addr_o,
  output logic [ID_W-1:0]                    out_req_id_o,
  output logic                               out_req_valid_o,
  input  logic                               out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]              out_rsp_data_i,
  input  logic                               out_rsp_error_i,
  input  logic [ID_W-1:0]                    out_rsp_id_i,
  input  logic                               out_rsp_valid_i,
  output logic                               out_rsp_ready_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e                       state_q;
  logic [PORT_IDX_W-1:0]            rr_ptr_q, grant_q;
  logic [NR_PORTS-1:0][CW-1:0]      cnt_q;
  logic [NR_PORTS-1:0]              elig, aged, dem_class, dem_oh, pf_oh, gnt_oh;
  logic [NR_PORTS-1:0]              cnt_inc, cnt_dec;
  logic [PORT_IDX_W-1:0]            dem_idx, pf_idx, gnt_idx, rsp_p;
  logic                             dem_valid, pf_valid, locked, gnt_valid;
  logic                             req_hs, rsp_hs, rsp_legal;

  always_comb begin
    elig = '0;
    for (int p = 0; p < int'(NR_PORTS); p++)
      elig[p] = in_req_valid_i[p] && (cnt_q[p] < CW'(MAX_OUTSTANDING));
  end

  assign dem_class = ~in_req_prefetch_i | aged;

  snitch_icache_rr_pick #(.N(NR_PORTS), .IW(PORT_IDX_W)) i_pick_demand (
    .elig   (elig & dem_class),
    .ptr    (rr_ptr_q),
    .onehot (dem_oh),
    .idx    (dem_idx),
    .valid  (dem_valid)
  );

  snitch_icache_rr_pick #(.N(NR_PORTS), .IW(PORT_IDX_W)) i_pick_prefetch (
    .elig   (elig & ~dem_class),
    .ptr    (rr_ptr_q),
    .onehot (pf_oh),
    .idx    (pf_idx),
    .valid  (pf_valid)
  );

  // While locked the arbiter is frozen on grant_q so the L1 sees a stable request.
  assign locked    = state_q == LOCKED;
  assign gnt_idx   = locked ? grant_q : (dem_valid ? dem_idx : pf_idx);
  assign gnt_oh    = locked ? (NR_PORTS'(1) << grant_q) : (dem_valid ? dem_oh : pf_oh);
  assign gnt_valid = locked ? in_req_valid_i[grant_q] : (dem_valid || pf_valid);

  assign out_req_valid_o = gnt_valid && !rst_i;
  assign out_req_addr_o  = in_req_addr_i[gnt_idx];
  assign out_req_id_o    = {gnt_idx, in_req_prefetch_i[gnt_idx]};
  assign in_req_ready_o  = gnt_oh & {NR_PORTS{out_req_valid_o && out_req_ready_i}};
  assign req_hs          = out_req_valid_o && out_req_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (!locked && gnt_valid && !out_req_ready_i) begin
        state_q <= LOCKED;
        grant_q <= gnt_idx;
      end else if (locked && out_req_ready_i) begin
        state_q <= IDLE;
      end
      if (req_hs)
        rr_ptr_q <= (int'(gnt_idx) == int'(NR_PORTS) - 1) ? '0 : gnt_idx + PORT_IDX_W'(1);
    end
  end

  // Responses are routed by the port index in the upper ID bits; bad indices are dropped.
  assign rsp_p           = out_rsp_id_i[ID_W-1:1];
  assign rsp_legal       = int'(rsp_p) < int'(NR_PORTS);
  assign in_rsp_data_o   = out_rsp_data_i;
  assign in_rsp_error_o  = out_rsp_error_i;
  assign in_rsp_id_o     = out_rsp_id_i;
  assign in_rsp_valid_o  = (out_rsp_valid_i && rsp_legal) ? (NR_PORTS'(1) << rsp_p) : '0;
  assign out_rsp_ready_o = rsp_legal ? in_rsp_ready_i[rsp_p] : 1'b1;
  assign rsp_hs          = out_rsp_valid_i && out_rsp_ready_o && rsp_legal;

  assign cnt_inc = req_hs ? gnt_oh : '0;
  assign cnt_dec = rsp_hs ? in_rsp_valid_o : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int p = 0; p < int'(NR_PORTS); p++) begin
        if (cnt_inc[p] && !cnt_dec[p])
          cnt_q[p] <= cnt_q[p] + CW'(1);
        else if (cnt_dec[p] && !cnt_inc[p])
          cnt_q[p] <= cnt_q[p] - CW'(1);
      end
    end
  end

`ifdef SNITCH_ICACHE_L0_ARB_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

  logic [NR_PORTS-1:0][AGE_W-1:0] age_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else begin
      for (int p = 0; p < int'(NR_PORTS); p++) begin
        if (!in_req_valid_i[p] || cnt_inc[p])
          age_q[p] <= '0;
        else if (elig[p] && in_req_prefetch_i[p] && age_q[p] != AGE_W'(AGE_LIMIT))
          age_q[p] <= age_q[p] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    aged = '0;
    for (int p = 0; p < int'(NR_PORTS); p++)
      aged[p] = age_q[p] == AGE_W'(AGE_LIMIT);
  end
`else
  assign aged = '0;
`endif

  assert property (@(posedge clk_i) disable iff (rst_i)
    out_req_valid_o && !out_req_ready_i |=>
      out_req_valid_o && $stable(out_req_addr_o) && $stable(out_req_id_o));

  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(in_req_ready_o));

  assert property (@(posedge clk_i) disable iff (rst_i) !(out_rsp_valid_i && !rsp_legal));

  assert property (@(posedge clk_i) disable iff (rst_i) !(rsp_hs && cnt_q[rsp_p] == '0));

  for (genvar i = 0; i < NR_PORTS; i++) begin : g_cnt_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      !(cnt_inc[i] && !cnt_dec[i] && cnt_q[i] == CW'(MAX_OUTSTANDING)));
    assert property (@(posedge clk_i) disable iff (rst_i)
      !(cnt_dec[i] && !cnt_inc[i] && cnt_q[i] == '0));
  end

endmodule

// File: tb/tb_snitch_icache_l0_refill_arbiter.sv
// tb_snitch_icache_l0_refill_arbiter: scoreboard bench for the L0 refill arbiter.
module tb_snitch_icache_l0_refill_arbiter;

  localparam int NR = 4, AW = 32, LW = 128, MAXO = 2, IW = 3;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, failures = 0;

  logic                  clk = 1'b0, rst = 1'b1;
  logic [NR-1:0][AW-1:0] addr;
  logic [NR-1:0]         pf, vld, rdy_o, rsp_vld_o, rsp_rdy;
  logic [LW-1:0]         rsp_data_o, ordata;
  logic                  rsp_err_o, oerr, ovld, ordy, orvld, orrdy_o;
  logic [IW-1:0]         rsp_id_o, oid, orid;
  logic [AW-1:0]         oaddr;

  snitch_icache_l0_refill_arbiter #(
    .NR_PORTS(NR), .FETCH_AW(AW), .LINE_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
`ifdef SNITCH_ICACHE_L0_ARB_AGING_EN
    , .AGE_LIMIT(4)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_req_addr_i(addr), .in_req_prefetch_i(pf), .in_req_valid_i(vld), .in_req_ready_o(rdy_o),
    .in_rsp_data_o(rsp_data_o), .in_rsp_error_o(rsp_err_o), .in_rsp_id_o(rsp_id_o),
    .in_rsp_valid_o(rsp_vld_o), .in_rsp_ready_i(rsp_rdy),
    .out_req_addr_o(oaddr), .out_req_id_o(oid), .out_req_valid_o(ovld), .out_req_ready_i(ordy),
    .out_rsp_data_i(ordata), .out_rsp_error_i(oerr), .out_rsp_id_i(orid),
    .out_rsp_valid_i(orvld), .out_rsp_ready_o(orrdy_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int p, bit is_pf);
    exp_t r;
    r.id   = {2'(p), is_pf};
    r.addr = addr[p];
    return r;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    vld = '0; pf = '0; ordy = 1'b0; orvld = 1'b0; orid = '0; rsp_rdy = '0;
    ordata = '0; oerr = 1'b0;
    exp_q.delete();
    for (int p = 0; p < NR; p++) addr[p] = 32'h8000_0000 | (p << 6);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    rst = 1'b1; vld = '1; ordy = 1'b1;
    orvld = 1'b1; orid = 3'b101; rsp_rdy = 4'b0100; oerr = 1'b1;
    ordata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checks++;
    if ({ovld, rdy_o} !== 5'b0) begin
      failures++; $display("FAIL reset_req: valid=%b ready=%b want 0/0000", ovld, rdy_o);
    end
    checks++;
    if ({rsp_vld_o, orrdy_o} !== 5'b0100_1) begin
      failures++; $display("FAIL reset_rsp_route: rsp_valid=%b rsp_ready=%b want 0100/1", rsp_vld_o, orrdy_o);
    end
    checks++;
    if ({rsp_data_o, rsp_err_o, rsp_id_o} !== {ordata, 1'b1, 3'b101}) begin
      failures++; $display("FAIL reset_rsp_data: id=%b err=%b want 101/1", rsp_id_o, rsp_err_o);
    end
    apply_reset();
  endtask

  task automatic test_demand_priority();
    apply_reset();
    ordy = 1'b1;
    @(negedge clk);
    vld = 4'b0101; pf = 4'b0001;
    exp_q.push_back(mk(2, 0));
    #1;
    checks++;
    if ({oid, rdy_o} !== {3'b100, 4'b0100}) begin
      failures++; $display("FAIL prio_id: id=%b ready=%b want 100/0100", oid, rdy_o);
    end
    e = exp_q.pop_front();
    checks++;
    if ({ovld, oid, oaddr} !== {1'b1, e}) begin
      failures++; $display("FAIL prio_grant: v=%b id=%b addr=%h want id=%b addr=%h", ovld, oid, oaddr, e.id, e.addr);
    end
    @(negedge clk);
    vld = 4'b1001; pf = '0;
    exp_q.push_back(mk(3, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({ovld, oid, oaddr, rdy_o} !== {1'b1, e, 4'b1000}) begin
      failures++; $display("FAIL prio_rrptr: v=%b id=%b ready=%b want id=%b ready=1000", ovld, oid, rdy_o, e.id);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vld = '1; pf = '0;
      exp_q.push_back(mk(i % NR, 0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({ovld, oid, oaddr, rdy_o} !== {1'b1, e, 4'(1 << (i % NR))}) begin
        failures++; $display("FAIL rr_grant%0d: v=%b id=%b ready=%b want id=%b", i, ovld, oid, rdy_o, e.id);
      end
    end
  endtask

  task automatic test_lock();
    apply_reset();
    @(negedge clk);
    vld = 4'b0010;
    exp_q.push_back(mk(1, 0));
    #1;
    checks++;
    if ({ovld, oid, rdy_o} !== {1'b1, 3'b010, 4'b0000}) begin
      failures++; $display("FAIL lock_first: v=%b id=%b ready=%b want 1/010/0000", ovld, oid, rdy_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld = 4'b0011;
      #1;
      checks++;
      if ({ovld, oid, oaddr, rdy_o} !== {1'b1, 3'b010, addr[1], 4'b0000}) begin
        failures++; $display("FAIL lock_hold%0d: v=%b id=%b addr=%h ready=%b want id=010 addr=%h", i, ovld, oid, oaddr, rdy_o, addr[1]);
      end
    end
    @(negedge clk);
    ordy = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({ovld, oid, oaddr, rdy_o} !== {1'b1, e, 4'b0010}) begin
      failures++; $display("FAIL lock_release: v=%b id=%b ready=%b want id=%b ready=0010", ovld, oid, rdy_o, e.id);
    end
    @(negedge clk);
    vld = 4'b0001;
    exp_q.push_back(mk(0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({ovld, oid, oaddr, rdy_o} !== {1'b1, e, 4'b0001}) begin
      failures++; $display("FAIL lock_next: v=%b id=%b ready=%b want id=%b ready=0001", ovld, oid, rdy_o, e.id);
    end
  endtask

  task automatic test_outstanding_cap();
    apply_reset();
    ordy = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      @(negedge clk);
      vld = 4'b1000;
      exp_q.push_back(mk(3, 0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({ovld, oid, oaddr, rdy_o} !== {1'b1, e, 4'b1000}) begin
        failures++; $display("FAIL cap_issue%0d: v=%b id=%b ready=%b want id=%b", i, ovld, oid, rdy_o, e.id);
      end
    end
    @(negedge clk);
    orvld = 1'b1; orid = 3'b110; rsp_rdy = 4'b1000;
    #1;
    checks++;
    if ({ovld, rdy_o} !== 5'b0) begin
      failures++; $display("FAIL cap_block: v=%b ready=%b want 0/0000", ovld, rdy_o);
    end
    checks++;
    if ({rsp_vld_o, orrdy_o} !== 5'b1000_1) begin
      failures++; $display("FAIL cap_rsp: rsp_valid=%b rsp_ready=%b want 1000/1", rsp_vld_o, orrdy_o);
    end
    @(negedge clk);
    orvld = 1'b0;
    exp_q.push_back(mk(3, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({ovld, oid, oaddr, rdy_o} !== {1'b1, e, 4'b1000}) begin
      failures++; $display("FAIL cap_reopen: v=%b id=%b ready=%b want id=%b ready=1000", ovld, oid, rdy_o, e.id);
    end
  endtask

  task automatic test_rsp_routing();
    apply_reset();
    ordy = 1'b1;
    @(negedge clk);
    vld = 4'b0010; pf = 4'b0010;
    exp_q.push_back(mk(1, 1));
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({ovld, oid, oaddr} !== {1'b1, e}) begin
      failures++; $display("FAIL route_issue: v=%b id=%b want id=%b", ovld, oid, e.id);
    end
    @(negedge clk);
    vld = '0; pf = '0;
    orvld = 1'b1; orid = 3'b011; rsp_rdy = 4'b1101; oerr = 1'b0;
    ordata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checks++;
    if ({rsp_vld_o, orrdy_o} !== 5'b0010_0) begin
      failures++; $display("FAIL route_stall: rsp_valid=%b rsp_ready=%b want 0010/0", rsp_vld_o, orrdy_o);
    end
    checks++;
    if ({rsp_data_o, rsp_err_o, rsp_id_o} !== {ordata, 1'b0, 3'b011}) begin
      failures++; $display("FAIL route_data: id=%b err=%b want 011/0", rsp_id_o, rsp_err_o);
    end
    @(negedge clk);
    rsp_rdy = 4'b1111;
    #1;
    checks++;
    if ({rsp_vld_o, orrdy_o} !== 5'b0010_1) begin
      failures++; $display("FAIL route_accept: rsp_valid=%b rsp_ready=%b want 0010/1", rsp_vld_o, orrdy_o);
    end
    for (int i = 0; i < MAXO; i++) begin
      @(negedge clk);
      orvld = 1'b0; vld = 4'b0010;
      exp_q.push_back(mk(1, 0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({ovld, oid, oaddr, rdy_o, rsp_vld_o} !== {1'b1, e, 4'b0010, 4'b0000}) begin
        failures++; $display("FAIL route_cnt_dec%0d: v=%b id=%b ready=%b rsp_valid=%b want id=%b", i, ovld, oid, rdy_o, rsp_vld_o, e.id);
      end
    end
  endtask

  task automatic test_aging();
    int m_cnt1 = 0;
    int n_cyc;
    int exp_p;
    apply_reset();
    ordy = 1'b1;
`ifdef SNITCH_ICACHE_L0_ARB_AGING_EN
    n_cyc = 5;
`else
    n_cyc = 20;
`endif
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      vld = 4'b0011; pf = 4'b0001;
      orvld = m_cnt1 > 0; orid = 3'b010; rsp_rdy = 4'b0010;
      exp_p = (n_cyc == 5 && i == 4) ? 0 : 1;
      exp_q.push_back(mk(exp_p, exp_p == 0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({ovld, oid, oaddr, rdy_o} !== {1'b1, e, 4'(1 << exp_p)}) begin
        failures++; $display("FAIL aging_cyc%0d: v=%b id=%b ready=%b want id=%b", i, ovld, oid, rdy_o, e.id);
      end
      m_cnt1 = m_cnt1 + (exp_p == 1 ? 1 : 0) - (orvld ? 1 : 0);
    end
    @(negedge clk);
    vld = '0; orvld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_demand_priority();
    test_round_robin();
    test_lock();
    test_outstanding_cap();
    test_rsp_routing();
    test_aging();
    apply_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
